serial_logic_unit: RTL and testbench

- Multi-cycle, parametrised bitwise logic/arithmetic unit. It processes two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, under a start/busy/done handshake.
- It generalises the team's single-bit NAND-derived gates (AND, OR, NOT, NOR, XOR) to N-bit words, and adds NAND, XNOR and an optional ripple-carry ADD.
- It sits between operand registers and the datapath writeback as a small-area alternative to a full-width combinational ALU.

---
 rtl/serial_logic_unit.sv | 176 +++++++++++++++++
 tb/tb_serial_logic_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_logic_unit.sv
// Chunk-serial bitwise logic unit: two WIDTH-bit operands, CHUNK bits per clock, LSB chunk first.
// Optional ripple-carry ADD on op 111 when SERIAL_LOGIC_UNIT_ADD_EN is defined (otherwise op 111 passes a).
module serial_logic_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic [1:0]       dbg_state
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0) begin : g_bad_cfg
    $error("serial_logic_unit: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b111;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic [CHUNK-1:0] a_c, b_c, chunk_res;
  logic             accept;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
  logic             carry_acc_q, carry_acc_d;
  logic [CHUNK:0]   sum;
`endif

  // Per-chunk datapath, always fed from the latched operands.
  always_comb begin
    a_c       = a_q[count_q*CHUNK +: CHUNK];
    b_c       = b_q[count_q*CHUNK +: CHUNK];
    chunk_res = '0;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
    sum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_acc_q};
`endif
    case (op_q)
      OP_AND:  chunk_res = a_c & b_c;
      OP_OR:   chunk_res = a_c | b_c;
      OP_XOR:  chunk_res = a_c ^ b_c;
      OP_NAND: chunk_res = ~(a_c & b_c);
      OP_NOR:  chunk_res = ~(a_c | b_c);
      OP_XNOR: chunk_res = ~(a_c ^ b_c);
      OP_NOT:  chunk_res = ~a_c;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
      OP_ADD:  chunk_res = sum[CHUNK-1:0];
`else
      OP_ADD:  chunk_res = a_c;
`endif
      default: chunk_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
    carry_acc_d = carry_acc_q;
`endif
    accept = 1'b0;

    case (state_q)
      S_IDLE: accept = start;
      S_RUN: begin
        work_d[count_q*CHUNK +: CHUNK] = chunk_res;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
        carry_acc_d = sum[CHUNK];
`endif
        if (count_q == LAST) begin
          // Publish the work register including the chunk finished this cycle.
          state_d  = S_DONE;
          result_d = work_d;
          zero_d   = (work_d == '0);
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
          carry_d  = (op_q == OP_ADD) ? sum[CHUNK] : 1'b0;
`else
          carry_d  = 1'b0;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        accept  = start;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_RUN;
      count_d = '0;
      a_d     = a;
      b_d     = b;
      op_d    = op;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
      carry_acc_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
      carry_acc_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
      carry_acc_q <= carry_acc_d;
`endif
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed-vector bench for serial_logic_unit at WIDTH=16, CHUNK=4 (N=4, done 5 cycles after start).
module tb_serial_logic_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, zero, carry;
  logic [15:0] result;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  serial_logic_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Drive start for one rising edge (cycle 0); returns at the middle of cycle 1.
  task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the middle of cycle 1, wait for done; lat is the cycle number done was seen in (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result got %h want 0000", result); end
    n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b want 0", zero); end
    n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b want 0", carry); end
    rst = 1'b0;
  endtask

  task automatic test_and_timing;
    issue(3'b000, 16'hF0F0, 16'hFF00);
    for (int c = 1; c <= 4; c++) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++; $display("FAIL and_busy cycle %0d got busy=%b done=%b want busy=1 done=0", c, busy, done);
      end
      @(negedge clk);
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL and_done cycle 5 got busy=%b done=%b want busy=0 done=1", busy, done);
    end
    n_vec++;
    if (result !== 16'hF000 || zero !== 1'b0 || carry !== 1'b0) begin
      n_err++; $display("FAIL and_result got %h z=%b c=%b want F000 z=0 c=0", result, zero, carry);
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL and_done_pulse got done=%b want 0", done); end
  endtask

  task automatic test_add;
    int lat;
    logic [15:0] exp_r;
    logic exp_z, exp_c;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
    exp_r = 16'h0000; exp_z = 1'b1; exp_c = 1'b1;
`else
    exp_r = 16'hFFFF; exp_z = 1'b0; exp_c = 1'b0;
`endif
    issue(3'b111, 16'hFFFF, 16'h0001);
    wait_done(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL add_latency got %0d want 5", lat); end
    n_vec++;
    if (result !== exp_r || zero !== exp_z || carry !== exp_c) begin
      n_err++; $display("FAIL add_result got %h z=%b c=%b want %h z=%b c=%b", result, zero, carry, exp_r, exp_z, exp_c);
    end
  endtask

  task automatic test_logic_ops;
    logic [2:0]  t_op [6] = '{3'b010, 3'b110, 3'b011, 3'b101, 3'b100, 3'b001};
    logic [15:0] t_a  [6] = '{16'h1234, 16'h00FF, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h000F};
    logic [15:0] t_b  [6] = '{16'h1234, 16'h1234, 16'hFFFF, 16'h0000, 16'h00FF, 16'h00F0};
    logic [15:0] t_r  [6] = '{16'h0000, 16'hFF00, 16'h0000, 16'hFFFF, 16'hF000, 16'h00FF};
    logic        t_z  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(lat);
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL logic_latency op=%b got %0d want 5", t_op[i], lat); end
      n_vec++;
      if (result !== t_r[i] || zero !== t_z[i] || carry !== 1'b0) begin
        n_err++; $display("FAIL logic_result op=%b got %h z=%b c=%b want %h z=%b c=0", t_op[i], result, zero, carry, t_r[i], t_z[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    issue(3'b001, 16'h000F, 16'h00F0);
    @(negedge clk);
    op = 3'b000; a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL ignore_done cycle 5 got %b want 1", done); end
    n_vec++; if (result !== 16'h00FF) begin n_err++; $display("FAIL ignore_result got %h want 00FF", result); end
    for (int c = 6; c <= 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL ignore_idle cycle %0d got busy=%b done=%b want 0 0", c, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [15:0] exp_r;
    issue(3'b111, 16'hFFFF, 16'h0001);
    wait_done(lat);
    @(negedge clk);
    issue(3'b111, 16'h1234, 16'h1111);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || zero !== 1'b0 || carry !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs got busy=%b done=%b r=%h z=%b c=%b want all 0", busy, done, result, zero, carry);
    end
    @(negedge clk);
    rst = 1'b0;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
    exp_r = 16'h2345;
`else
    exp_r = 16'h1234;
`endif
    issue(3'b111, 16'h1234, 16'h1111);
    wait_done(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL midreset_latency got %0d want 5", lat); end
    n_vec++;
    if (result !== exp_r || carry !== 1'b0 || zero !== 1'b0) begin
      n_err++; $display("FAIL midreset_result got %h z=%b c=%b want %h z=0 c=0", result, zero, carry, exp_r);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(3'b000, 16'hF0F0, 16'hFF00);
    wait_done(lat);
    n_vec++; if (lat !== 5 || result !== 16'hF000) begin n_err++; $display("FAIL b2b_first got lat=%0d r=%h want 5 F000", lat, result); end
    op = 3'b010; a = 16'h00FF; b = 16'h0F0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== 16'hF000) begin
        n_err++; $display("FAIL b2b_hold cycle %0d got busy=%b done=%b r=%h want 1 0 F000", c, busy, done, result);
      end
      @(negedge clk);
    end
    n_vec++;
    if (done !== 1'b1 || result !== 16'h0FF0 || zero !== 1'b0) begin
      n_err++; $display("FAIL b2b_second cycle 10 got done=%b r=%h z=%b want 1 0FF0 0", done, result, zero);
    end
  endtask

  initial begin
    test_reset();
    test_and_timing();
    test_add();
    test_logic_ops();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want bench completion");
    $fatal(1, "watchdog");
  end
endmodule
